ahb_slave_ram_bridge: RTL and testbench
=======================================

Name: ahb_slave_ram_bridge

Overview:
AHB slave front-end that converts AHB-Lite transfers into a simple synchronous RAM port (separate read/write strobes, addresses and byte selects). It includes a synthesizable pseudo-random HREADY stall generator with burst stalls, plus address-triggered error-response and timeout injection. It sits between an AHB interconnect and a RAM model in verification or bring-up systems.

Parameters:
ADDR_BITS, 24, AHB/RAM address width.
DATA_BITS, 32, data width; only 32 or 64 are legal.
STALL_CHANCE, 13, per-cycle stall probability in units of 1/128.
BURST_CHANCE, 1, per-cycle probability, in 1/128, of entering a stall burst.
BURST_LEN, 10, stall-burst length in cycles.
BURST_VAL, 115, stall probability in 1/128 during a burst.
LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
HADDR  in  ADDR_BITS  AHB address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  write when 1
HSIZE  in  2  00 byte, 01 half, 10 word, 11 dword
HWDATA  in  DATA_BITS  write data
HRDATA  out  DATA_BITS  read data
HREADY  out  1  transfer ready
HRESP  out  1  error response
stall_enable  in  1  enables random stalls
cfg_hresp_addr  in  ADDR_BITS  address that triggers HRESP
cfg_timeout_addr  in  ADDR_BITS  address that triggers permanent stall; 0 clears it
WR  out  1  RAM write strobe
RD  out  1  RAM read strobe
ADDR_WR  out  ADDR_BITS  RAM write address
ADDR_RD  out  ADDR_BITS  RAM read address
DIN  out  DATA_BITS  RAM write data
DOUT  in  DATA_BITS  RAM read data, valid the cycle after RD
BSEL  out  DATA_BITS/8  write byte enables

Behaviour:
- Single clock `clk`; all registers use `reset` as a synchronous, active-high reset.
- Reset values: STALL=0, timeout_stall=0, HRESP=0, data_phase=0, WR_pre_d=0, ADDR_WR=0, HSIZE_d=0, LFSR=LFSR_SEED, burst counter=0.
- Active transfer: act = HTRANS is NONSEQ or SEQ.
- HREADY = 0 when HTRANS==BUSY; otherwise HREADY = ~timeout_stall & ~STALL. HREADY is combinational.
- RD = ~HWRITE & act & HREADY. ADDR_RD = HADDR when RD, else 0. All are combinational.
- Write pipeline registers load only when HREADY=1:
  - WR_pre_d <= HWRITE & act.
  - ADDR_WR <= HADDR when HWRITE & act, else 0.
  - HSIZE_d <= HSIZE.
- WR = WR_pre_d & HREADY. DIN = HWDATA, combinational.
- Read data phase:
  - data_phase <= 1 on RD; otherwise it clears to 0 when HREADY=1.
  - HRDATA = DOUT when HREADY & data_phase, else 0.
- HRESP register:
  - Set to 1 when HTRANS!=IDLE and HADDR==cfg_hresp_addr.
  - Otherwise cleared when HREADY=1; set has priority.
- timeout_stall register:
  - Set to 1 when HTRANS!=IDLE and HADDR==cfg_timeout_addr.
  - Otherwise cleared when cfg_timeout_addr==0; holds in all other cases.
- Byte lanes, wide8 computed from HSIZE_d and ADDR_WR[2:0]:
  - size 00: one-hot bit ADDR_WR[2:0].
  - size 01: 2'b11 shifted by 2*ADDR_WR[2:1].
  - size 10: 4'hF shifted by 4*ADDR_WR[2].
  - size 11: 8'hFF.
  - DATA_BITS=64: BSEL = wide8.
  - DATA_BITS=32: BSEL = ADDR_WR[2] ? wide8[7:4] : wide8[3:0].
- Stall generator:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
  - chance = BURST_VAL while the burst counter is nonzero, else STALL_CHANCE.
  - stall_pre = (LFSR[6:0] < chance).
  - STALL <= stall_enable & stall_pre; one-cycle latency.
  - Burst entry: when the counter is 0 and LFSR[14:8] < BURST_CHANCE, load the counter with BURST_LEN. A nonzero counter decrements each cycle. BURST_CHANCE=0 disables bursts.
- Simultaneous events: RD and the data_phase clear in the same cycle resolve as set. A write data phase and a new read address phase in the same cycle both proceed.

Test Plan:
1. stall_enable=0, cfg addrs=all-ones; NONSEQ write HADDR=0x10, HSIZE=10, HWDATA=0xDEADBEEF; next cycle IDLE -> WR=1, ADDR_WR=0x10, BSEL=4'b1111, DIN=0xDEADBEEF, HREADY=1 throughout.
2. NONSEQ read HADDR=0x10 -> same cycle RD=1, ADDR_RD=0x10; next cycle HRDATA=DOUT; in an idle cycle with no pending read, HRDATA=0.
3. Byte write HSIZE=00 at HADDR=0x5, DATA_BITS=32 -> BSEL=4'b0010; half-word at 0x6 -> BSEL=4'b1100.
4. HTRANS=BUSY -> HREADY=0, RD=0. With cfg_hresp_addr=0x20, access at 0x20 -> HRESP=1 next cycle, cleared on a following HREADY cycle.
5. With cfg_timeout_addr=0x30, access at 0x30 -> HREADY stays 0 indefinitely. Set cfg_timeout_addr=0 -> HREADY=1 the cycle after.
6. stall_enable=1, STALL_CHANCE=64, 1000 idle cycles -> HREADY low in roughly 40–60% of cycles. Reset mid-stall -> HREADY=1 the cycle after reset, all strobes 0.

Source files
------------

// File: rtl/ahb_slave_ram_bridge.sv
// AHB-Lite slave front-end driving a simple synchronous RAM port,
// with LFSR-driven HREADY stalls and address-triggered error/timeout injection.
module ahb_slave_ram_bridge #(
    parameter int          ADDR_BITS    = 24,
    parameter int          DATA_BITS    = 32,
    parameter int          STALL_CHANCE = 13,
    parameter int          BURST_CHANCE = 1,
    parameter int          BURST_LEN    = 10,
    parameter int          BURST_VAL    = 115,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_BITS-1:0]   HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [1:0]             HSIZE,
    input  logic [DATA_BITS-1:0]   HWDATA,
    output logic [DATA_BITS-1:0]   HRDATA,
    output logic                   HREADY,
    output logic                   HRESP,
    input  logic                   stall_enable,
    input  logic [ADDR_BITS-1:0]   cfg_hresp_addr,
    input  logic [ADDR_BITS-1:0]   cfg_timeout_addr,
    output logic                   WR,
    output logic                   RD,
    output logic [ADDR_BITS-1:0]   ADDR_WR,
    output logic [ADDR_BITS-1:0]   ADDR_RD,
    output logic [DATA_BITS-1:0]   DIN,
    input  logic [DATA_BITS-1:0]   DOUT,
    output logic [DATA_BITS/8-1:0] BSEL
);
    localparam int CW = $clog2(BURST_LEN + 2);

    logic                 r_stall;
    logic                 r_timeout;
    logic                 r_hresp;
    logic                 r_dphase;
    logic                 r_wr_pre;
    logic [ADDR_BITS-1:0] r_addr_wr;
    logic [1:0]           r_hsize_d;
    logic [15:0]          r_lfsr;
    logic [CW-1:0]        r_burst;

    logic       w_act;
    logic       w_nidle;
    logic       w_ready;
    logic       w_rd;
    logic       w_fb;
    logic [7:0] w_chance;
    logic       w_stall_pre;
    logic       w_burst_go;
    logic [7:0] w_wide8;

    assign w_act   = HTRANS[1];
    assign w_nidle = HTRANS != 2'b00;
    assign w_ready = (HTRANS != 2'b01) & ~r_timeout & ~r_stall;
    assign w_rd    = ~HWRITE & w_act & w_ready;

    assign HREADY  = w_ready;
    assign HRESP   = r_hresp;
    assign RD      = w_rd;
    assign ADDR_RD = w_rd ? HADDR : '0;
    assign WR      = r_wr_pre & w_ready;
    assign ADDR_WR = r_addr_wr;
    assign DIN     = HWDATA;
    assign HRDATA  = (w_ready & r_dphase) ? DOUT : '0;

    // Stall odds rise while a burst is running
    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_chance    = (r_burst != '0) ? 8'(BURST_VAL) : 8'(STALL_CHANCE);
    assign w_stall_pre = {1'b0, r_lfsr[6:0]} < w_chance;
    assign w_burst_go  = (r_burst == '0) &&
                         ({1'b0, r_lfsr[14:8]} < 8'(BURST_CHANCE));

    always_comb begin
        w_wide8 = 8'hFF;
        case (r_hsize_d)
            2'b00:   w_wide8 = 8'b1 << r_addr_wr[2:0];
            2'b01:   w_wide8 = 8'b11 << {r_addr_wr[2:1], 1'b0};
            2'b10:   w_wide8 = 8'hF << {r_addr_wr[2], 2'b00};
            default: w_wide8 = 8'hFF;
        endcase
    end

    generate
        if (DATA_BITS == 64) begin : g_bsel64
            assign BSEL = w_wide8;
        end else begin : g_bsel32
            assign BSEL = r_addr_wr[2] ? w_wide8[7:4] : w_wide8[3:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall   <= 1'b0;
            r_timeout <= 1'b0;
            r_hresp   <= 1'b0;
            r_dphase  <= 1'b0;
            r_wr_pre  <= 1'b0;
            r_addr_wr <= '0;
            r_hsize_d <= 2'b00;
            r_lfsr    <= LFSR_SEED;
            r_burst   <= '0;
        end else begin
            r_lfsr  <= {r_lfsr[14:0], w_fb};
            r_stall <= stall_enable & w_stall_pre;

            if (w_burst_go)
                r_burst <= CW'(BURST_LEN);
            else if (r_burst != '0)
                r_burst <= r_burst - CW'(1);

            if (w_ready) begin
                r_wr_pre  <= HWRITE & w_act;
                r_addr_wr <= (HWRITE & w_act) ? HADDR : '0;
                r_hsize_d <= HSIZE;
            end

            // A new read wins over the clear of the previous data phase
            if (w_rd)
                r_dphase <= 1'b1;
            else if (w_ready)
                r_dphase <= 1'b0;

            if (w_nidle && HADDR == cfg_hresp_addr)
                r_hresp <= 1'b1;
            else if (w_ready)
                r_hresp <= 1'b0;

            if (w_nidle && HADDR == cfg_timeout_addr)
                r_timeout <= 1'b1;
            else if (cfg_timeout_addr == '0)
                r_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb_slave_ram_bridge.sv
// Directed bench for ahb_slave_ram_bridge with a scoreboard queue
// and a small byte-lane RAM model behind the bridge.
module tb_ahb_slave_ram_bridge;
    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [1:0]    HSIZE;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;
    logic          stall_enable;
    logic [AW-1:0] cfg_hresp_addr;
    logic [AW-1:0] cfg_timeout_addr;
    logic          WR;
    logic          RD;
    logic [AW-1:0] ADDR_WR;
    logic [AW-1:0] ADDR_RD;
    logic [DW-1:0] DIN;
    logic [DW-1:0] DOUT;
    logic [3:0]    BSEL;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:63];

    ahb_slave_ram_bridge #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .STALL_CHANCE(64)
    ) dut (
        .clk(clk), .reset(reset), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .stall_enable(stall_enable), .cfg_hresp_addr(cfg_hresp_addr),
        .cfg_timeout_addr(cfg_timeout_addr), .WR(WR), .RD(RD),
        .ADDR_WR(ADDR_WR), .ADDR_RD(ADDR_RD), .DIN(DIN),
        .DOUT(DOUT), .BSEL(BSEL)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (WR)
            for (int b = 0; b < 4; b++)
                if (BSEL[b])
                    mem[ADDR_WR[7:2]][8*b +: 8] <= DIN[8*b +: 8];
        if (RD)
            DOUT <= mem[ADDR_RD[7:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=%0h expected=entry", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    int lows;
    int hi_cnt;
    bit found;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        DOUT = '0;
        reset = 1'b1;
        HADDR = '0;
        HSIZE = 2'b10;
        HWDATA = '0;
        stall_enable = 1'b0;
        cfg_hresp_addr = '1;
        cfg_timeout_addr = '1;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_hready", HREADY, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_wr", WR, 0);
        chk("rst_rd", RD, 0);
        chk("rst_hrdata", HRDATA, 0);

        // word write
        tick();
        HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 'h10; HSIZE = 2'b10;
        push("w_addr", 'h10);
        push("w_bsel", 'hF);
        push("w_din", 'hDEADBEEF);
        @(negedge clk);
        chk("w_aph_hready", HREADY, 1);
        chk("w_aph_wr", WR, 0);
        tick();
        idle(); HWDATA = 32'hDEADBEEF;
        @(negedge clk);
        chk("w_dph_wr", WR, 1);
        chk("w_dph_hready", HREADY, 1);
        pop_chk(ADDR_WR);
        pop_chk(BSEL);
        pop_chk(DIN);

        // word read back
        tick();
        HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 'h10;
        push("r_rdata", 'hDEADBEEF);
        @(negedge clk);
        chk("r_rd", RD, 1);
        chk("r_addr_rd", ADDR_RD, 'h10);
        tick();
        idle(); HADDR = 'h44;
        @(negedge clk);
        chk("r_rd_idle", RD, 0);
        chk("r_addr_rd_idle", ADDR_RD, 0);
        pop_chk(HRDATA);
        tick();
        @(negedge clk);
        chk("r_hrdata_idle", HRDATA, 0);

        // byte then half-word write, pipelined
        tick();
        HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 'h5; HSIZE = 2'b00;
        push("b_bsel", 4'b0010);
        @(negedge clk);
        tick();
        HTRANS = 2'b11; HADDR = 'h6; HSIZE = 2'b01; HWDATA = 32'h0000AB00;
        push("h_addr", 'h6);
        push("h_bsel", 4'b1100);
        @(negedge clk);
        chk("b_wr", WR, 1);
        chk("b_addr", ADDR_WR, 'h5);
        pop_chk(BSEL);
        tick();
        idle(); HWDATA = 32'h12340000;
        @(negedge clk);
        chk("h_wr", WR, 1);
        pop_chk(ADDR_WR);
        pop_chk(BSEL);
        tick();
        HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 'h4; HSIZE = 2'b10;
        push("bh_rdata", 'h1234AB00);
        @(negedge clk);
        chk("bh_rd", RD, 1);
        tick();
        idle();
        @(negedge clk);
        pop_chk(HRDATA);

        // BUSY and error response
        tick();
        HTRANS = 2'b01; HWRITE = 1'b0; HADDR = 'h40;
        @(negedge clk);
        chk("busy_hready", HREADY, 0);
        chk("busy_rd", RD, 0);
        tick();
        idle();
        cfg_hresp_addr = 'h20;
        @(negedge clk);
        chk("busy_recover", HREADY, 1);
        tick();
        HTRANS = 2'b10; HADDR = 'h20;
        @(negedge clk);
        chk("hresp_pre", HRESP, 0);
        tick();
        idle();
        @(negedge clk);
        chk("hresp_set", HRESP, 1);
        tick();
        cfg_hresp_addr = '1;
        @(negedge clk);
        chk("hresp_clr", HRESP, 0);

        // timeout injection
        tick();
        cfg_timeout_addr = 'h30;
        HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 'h30;
        @(negedge clk);
        chk("to_first", HREADY, 1);
        tick();
        idle();
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (HREADY !== 1'b0) hi_cnt++;
            tick();
        end
        chk("to_held", hi_cnt, 0);
        cfg_timeout_addr = '0;
        @(negedge clk);
        chk("to_clr_same", HREADY, 0);
        tick();
        @(negedge clk);
        chk("to_clr_next", HREADY, 1);
        tick();
        cfg_timeout_addr = '1;

        // random stalls
        stall_enable = 1'b1;
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (HREADY === 1'b0) lows++;
        end
        chk("stall_rate", (lows >= 350 && lows <= 700), 1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (HREADY === 1'b0) found = 1;
        end
        chk("stall_seen", found, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_hready", HREADY, 1);
        chk("mid_rst_wr", WR, 0);
        chk("mid_rst_rd", RD, 0);
        chk("mid_rst_hresp", HRESP, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
